// File: rtl/ll_push_arbiter.sv
// ll_push_arbiter: per-source one-entry staging with round-robin push onto a shared linked-list FIFO
module ll_push_arbiter #(
  parameter int WIDTH = 8,
  parameter int NUM_FIFOS = 2,
  parameter int SEL_WIDTH = $clog2(NUM_FIFOS)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_FIFOS-1:0]       in_valid,
  input  logic [NUM_FIFOS*WIDTH-1:0] in_data,
  output logic [NUM_FIFOS-1:0]       in_ready,
  input  logic                       full,
  output logic                       push,
  output logic [SEL_WIDTH-1:0]       push_sel,
  output logic [WIDTH-1:0]           data_in,
  output logic [NUM_FIFOS-1:0]       grant_onehot
);
  logic [NUM_FIFOS-1:0] stage_valid_q, stage_valid_d;
  logic [WIDTH-1:0]     stage_data_q [NUM_FIFOS];
  logic [SEL_WIDTH-1:0] last_grant_q, last_grant_d;
  logic [SEL_WIDTH-1:0] g, idx;
  logic                 found;
  logic                 any_req;
  always_comb begin
    g = '0;
    idx = '0;
    found = 1'b0;
    for (int k = 1; k <= NUM_FIFOS; k++) begin
      idx = SEL_WIDTH'((int'(last_grant_q) + k) % NUM_FIFOS);
      if (!found && stage_valid_q[idx]) begin
        g = idx;
        found = 1'b1;
      end
    end
  end
  assign any_req       = |stage_valid_q;
  assign push          = !rst && !full && any_req;
  assign push_sel      = any_req ? g : '0;
  assign data_in       = any_req ? stage_data_q[g] : '0;
  assign grant_onehot  = push ? NUM_FIFOS'(1) << g : '0;
  assign in_ready      = {NUM_FIFOS{!rst}} & (~stage_valid_q | grant_onehot);
  assign stage_valid_d = (stage_valid_q & ~grant_onehot) | (in_valid & in_ready);
  assign last_grant_d  = push ? g : last_grant_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      stage_valid_q <= '0;
      last_grant_q  <= SEL_WIDTH'(NUM_FIFOS - 1);
    end else begin
      stage_valid_q <= stage_valid_d;
      last_grant_q  <= last_grant_d;
    end
  end
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_FIFOS; i++)
      if (in_valid[i] && in_ready[i]) stage_data_q[i] <= in_data[i*WIDTH +: WIDTH];
  end
endmodule

// File: tb/tb_ll_push_arbiter.sv
// tb_ll_push_arbiter: scenario tasks plus a per-source scoreboard checking every push
module tb_ll_push_arbiter;
  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  in_valid;
  logic [15:0] in_data;
  logic [1:0]  in_ready;
  logic        full;
  logic        push;
  logic        push_sel;
  logic [7:0]  data_in;
  logic [1:0]  grant_onehot;
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [7:0]  q0[$];
  logic [7:0]  q1[$];

  ll_push_arbiter #(.WIDTH(8), .NUM_FIFOS(2)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .full(full), .push(push), .push_sel(push_sel), .data_in(data_in), .grant_onehot(grant_onehot)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  always @(negedge clk) begin
    logic [7:0] exp_d;
    logic       have;
    if (rst === 1'b1) begin
      q0.delete();
      q1.delete();
    end else begin
      if (push === 1'b1) begin
        have = 1'b0;
        exp_d = '0;
        if (push_sel === 1'b0 && q0.size() > 0) begin exp_d = q0.pop_front(); have = 1'b1; end
        else if (push_sel === 1'b1 && q1.size() > 0) begin exp_d = q1.pop_front(); have = 1'b1; end
        n_cmp++;
        if (!have || data_in !== exp_d) begin
          n_bad++;
          $display("FAIL scoreboard sel=%0d got %h exp %h (expected present=%0d)", push_sel, data_in, exp_d, have);
        end
      end
      if (in_valid[0] === 1'b1 && in_ready[0] === 1'b1) q0.push_back(in_data[7:0]);
      if (in_valid[1] === 1'b1 && in_ready[1] === 1'b1) q1.push_back(in_data[15:8]);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 2'b11; in_data = 16'hBBAA; full = 1'b0;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      n_cmp++;
      if ({in_ready, push, grant_onehot} !== 5'b0) begin
        n_bad++;
        $display("FAIL reset_hold cyc%0d in_ready=%b push=%b grant=%b exp all 0", c, in_ready, push, grant_onehot);
      end
      tick();
    end
    rst = 1'b0; in_valid = 2'b00;
    @(negedge clk);
    n_cmp++;
    if ({in_ready, push} !== 3'b110) begin
      n_bad++;
      $display("FAIL reset_release in_ready=%b push=%b exp 11 0", in_ready, push);
    end
  endtask

  task automatic test_single();
    logic [7:0] vals [3];
    vals[0] = 8'h11; vals[1] = 8'h22; vals[2] = 8'h33;
    for (int i = 0; i <= 3; i++) begin
      tick();
      in_valid = (i < 3) ? 2'b10 : 2'b00;
      in_data = {(i < 3) ? vals[i] : 8'h00, 8'h00};
      @(negedge clk);
      if (i < 3) begin
        n_cmp++;
        if (in_ready[1] !== 1'b1) begin
          n_bad++;
          $display("FAIL single_ready i=%0d got %b exp 1", i, in_ready[1]);
        end
      end
      if (i > 0) begin
        n_cmp++;
        if ({push, push_sel, data_in, grant_onehot} !== {1'b1, 1'b1, vals[i-1], 2'b10}) begin
          n_bad++;
          $display("FAIL single_push i=%0d got push=%b sel=%b data=%h grant=%b exp 1 1 %h 10", i, push, push_sel, data_in, grant_onehot, vals[i-1]);
        end
      end
    end
    tick();
    @(negedge clk);
    n_cmp++;
    if (push !== 1'b0) begin
      n_bad++;
      $display("FAIL single_idle push=%b exp 0", push);
    end
  endtask

  task automatic test_round_robin();
    logic [7:0] c0, c1;
    logic [1:0] hs;
    logic [7:0] exp_d;
    logic [1:0] exp_r;
    tick();
    rst = 1'b1; in_valid = 2'b00;
    tick();
    rst = 1'b0; in_valid = 2'b11;
    c0 = 8'hA0; c1 = 8'hB0;
    in_data = {c1, c0};
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (c == 0) begin
        n_cmp++;
        if ({in_ready, push} !== 3'b110) begin
          n_bad++;
          $display("FAIL rr_start in_ready=%b push=%b exp 11 0", in_ready, push);
        end
      end else begin
        exp_d = ((c - 1) % 2 == 1) ? 8'hB0 + 8'((c - 1) / 2) : 8'hA0 + 8'((c - 1) / 2);
        exp_r = ((c - 1) % 2 == 1) ? 2'b10 : 2'b01;
        n_cmp++;
        if ({push, push_sel, data_in, in_ready, grant_onehot} !== {1'b1, exp_r[1], exp_d, exp_r, exp_r}) begin
          n_bad++;
          $display("FAIL rr_push k=%0d got push=%b sel=%b data=%h ready=%b grant=%b exp 1 %b %h %b %b",
                   c - 1, push, push_sel, data_in, in_ready, grant_onehot, exp_r[1], exp_d, exp_r, exp_r);
        end
      end
      hs = in_valid & in_ready;
      tick();
      if (hs[0]) c0 = c0 + 8'd1;
      if (hs[1]) c1 = c1 + 8'd1;
      in_data = {c1, c0};
    end
    in_valid = 2'b00;
    repeat (3) tick();
  endtask

  task automatic test_full_backpressure();
    tick();
    in_valid = 2'b01; in_data = 16'h005A; full = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (in_ready[0] !== 1'b1) begin
      n_bad++;
      $display("FAIL full_accept in_ready0=%b exp 1", in_ready[0]);
    end
    tick();
    in_valid = 2'b00; full = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      n_cmp++;
      if ({push, in_ready[0]} !== 2'b00) begin
        n_bad++;
        $display("FAIL full_hold cyc%0d push=%b in_ready0=%b exp 0 0", c, push, in_ready[0]);
      end
      tick();
    end
    full = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({push, push_sel, data_in} !== {1'b1, 1'b0, 8'h5A}) begin
      n_bad++;
      $display("FAIL full_release push=%b sel=%b data=%h exp 1 0 5a", push, push_sel, data_in);
    end
  endtask

  task automatic test_priority_under_full();
    tick();
    in_valid = 2'b11; in_data = 16'hC1C0; full = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({in_ready, push} !== 3'b110) begin
      n_bad++;
      $display("FAIL prio_accept in_ready=%b push=%b exp 11 0", in_ready, push);
    end
    tick();
    in_valid = 2'b00;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_cmp++;
      if (push !== 1'b0) begin
        n_bad++;
        $display("FAIL prio_full cyc%0d push=%b exp 0", c, push);
      end
      tick();
    end
    full = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({push, push_sel, data_in} !== {1'b1, 1'b1, 8'hC1}) begin
      n_bad++;
      $display("FAIL prio_first push=%b sel=%b data=%h exp 1 1 c1", push, push_sel, data_in);
    end
    tick();
    @(negedge clk);
    n_cmp++;
    if ({push, push_sel, data_in} !== {1'b1, 1'b0, 8'hC0}) begin
      n_bad++;
      $display("FAIL prio_second push=%b sel=%b data=%h exp 1 0 c0", push, push_sel, data_in);
    end
    tick();
  endtask

  task automatic test_reset_midop();
    in_valid = 2'b01; in_data = 16'h0077;
    @(negedge clk);
    tick();
    in_valid = 2'b00; rst = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({push, grant_onehot, in_ready} !== 5'b0) begin
      n_bad++;
      $display("FAIL midrst_hold push=%b grant=%b ready=%b exp 0", push, grant_onehot, in_ready);
    end
    tick();
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_cmp++;
      if ({push, in_ready} !== 3'b011) begin
        n_bad++;
        $display("FAIL midrst_after cyc%0d push=%b in_ready=%b exp 0 11", c, push, in_ready);
      end
      tick();
    end
  endtask

  task automatic test_drained();
    n_cmp++;
    if (q0.size() + q1.size() != 0) begin
      n_bad++;
      $display("FAIL drained q0=%0d q1=%0d exp 0 0", q0.size(), q1.size());
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_full_backpressure();
    test_priority_under_full();
    test_reset_midop();
    test_drained();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/ll_push_arbiter.md
Name: ll_push_arbiter

Overview:
- Upstream ingress stage for the shared linked-list FIFO.
- Accepts up to NUM_FIFOS independent producer streams, each on a valid/ready handshake, and holds each in a one-entry staging register.
- Round-robin arbitrates one staged word per cycle onto the FIFO's single push / push_sel / data_in interface.
- Never pushes while the FIFO reports full, so push-side environment constraints hold by construction.

Parameters:
- WIDTH, 8, data word width
- NUM_FIFOS, 2, number of producer streams / logical queues (legal values: 2 or more)
- SEL_WIDTH, $clog2(NUM_FIFOS), width of push_sel

Ports:
- clk  input  1  clock; all state updates on posedge
- rst  input  1  synchronous, active-high reset
- in_valid  input  NUM_FIFOS  per-source word valid
- in_data  input  NUM_FIFOS*WIDTH  per-source data; source i occupies bits [i*WIDTH +: WIDTH]
- in_ready  output  NUM_FIFOS  per-source ready; transfer on in_valid[i] & in_ready[i]
- full  input  1  full flag from the shared FIFO
- push  output  1  push strobe to the shared FIFO
- push_sel  output  SEL_WIDTH  target queue of the push
- data_in  output  WIDTH  push data to the shared FIFO
- grant_onehot  output  NUM_FIFOS  one-hot copy of push_sel, qualified by push (debug/verification)

Behaviour:
- State: stage_valid[NUM_FIFOS], stage_data[NUM_FIFOS][WIDTH], last_grant[SEL_WIDTH].
- Reset, on a posedge with rst=1:
  - stage_valid <= 0; last_grant <= NUM_FIFOS-1, so source 0 has first priority.
  - stage_data is don't-care.
  - While rst=1, push=0, grant_onehot=0 and in_ready=0 combinationally.
  - Reset mid-operation discards staged words. Words pushed in earlier cycles are unaffected.
- Arbitration is combinational from registered state:
  - req = stage_valid.
  - Search order is last_grant+1, last_grant+2, ... modulo NUM_FIFOS, wrapping from NUM_FIFOS-1 to 0. Modulo is explicit, not bit-wrap, for non-power-of-2 NUM_FIFOS.
  - The first set req bit is the winner g.
- Push:
  - push = !rst & !full & |stage_valid.
  - push_sel = g and data_in = stage_data[g] whenever |stage_valid, independent of full.
  - When no request is staged, push_sel=0 and data_in=0.
  - grant_onehot = push ? (1<<g) : 0.
- On a push cycle: stage_valid[g] clears and last_grant <= g.
- If full=1: no grant, last_grant holds, all stages hold. Priority is not lost while the FIFO is full.
- in_ready[i] = !rst & (!stage_valid[i] | grant_onehot[i]). A granted stage may be refilled in the same cycle.
- On in_valid[i] & in_ready[i]: stage_valid[i] <= 1 and stage_data[i] <= in_data slice i. This takes precedence over the clear from a same-cycle grant.
- Latency: a word accepted at edge N is pushed at the earliest in cycle N+1, i.e. the push is seen at edge N+1 by the FIFO.
- Throughput:
  - One push per cycle aggregate.
  - A single continuously valid source reaches 1 word/cycle when alone.
  - With k active sources, each gets 1/k.
- Ordering: per-source order is preserved because each source has one stage entry.
- Fairness: a staged request waits at most NUM_FIFOS-1 non-full grant cycles.
- Outputs are functions of registered state plus full/rst only. No combinational path from in_valid or in_data to push, push_sel or data_in.
- Pop side is not handled here. full is sampled only as an input.

Test Plan:
- Reset: assert rst 2 cycles with in_valid=2'b11 -> in_ready=0, push=0, grant_onehot=0 throughout. First cycle after release -> in_ready=2'b11, push=0.
- Single source streaming, NUM_FIFOS=2, source 1 sends 0x11,0x22,0x33 back-to-back, full=0 -> push=1 for 3 consecutive cycles starting 1 cycle after the first acceptance; push_sel=1; data_in=0x11,0x22,0x33; in_ready[1] stays 1.
- Round-robin: both sources continuously valid (src0 0xA0.., src1 0xB0..), full=0 -> push_sel sequence 0,1,0,1, with src0 winning first after reset; in_ready toggles per source accordingly.
- Full backpressure: stage src0=0x5A, hold full=1 for 4 cycles -> push=0 and in_ready[0]=0 for all 4 cycles. Drop full -> push=1, push_sel=0, data_in=0x5A in that same cycle.
- Priority retention under full: last_grant=0, stage both sources, full=1 for 3 cycles then 0 -> first push after release has push_sel=1.
- Reset mid-operation: stage src0=0x77, assert rst 1 cycle before a grant -> 0x77 is never pushed; push=0 on the cycle after rst deasserts.
